act_mem_rd_streamer: RTL and testbench

Read-side streamer directly downstream of the activation memory wrapper. It walks a configured address sequence and drives the memory's internal read port (`rd_enable`/`rd_addr`). It captures `rd_data` one cycle later into a small credit-protected FIFO and presents activation words to the PE array over a valid/ready handshake. Backpressure from the array never drops a word; external (debug/DMA) reads on the memory take precedence and stall the streamer.

---
 rtl/act_mem_rd_streamer.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_act_mem_rd_streamer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_mem_rd_streamer.sv
// Activation memory read streamer: walks base+k*stride, captures read data into a
// credit-protected FIFO and streams it out over valid/ready. Optional ACT_STREAMER_ZERO_PAD_EN.
module act_mem_rd_streamer #(
    parameter int unsigned SRAM_numBit         = 8,
    parameter int unsigned SRAM_blocks_per_row = 4,
    parameter int unsigned SRAM_totalWordAddr  = 10,
    parameter int unsigned FIFO_DEPTH          = 4,
    parameter int unsigned LEN_W               = 12
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        start,
    input  logic                                        clear,
    input  logic [SRAM_totalWordAddr-1:0]               cfg_base,
    input  logic [SRAM_totalWordAddr-1:0]               cfg_stride,
    input  logic [LEN_W-1:0]                            cfg_len,
`ifdef ACT_STREAMER_ZERO_PAD_EN
    input  logic [3:0]                                  cfg_pad_pre,
    input  logic [3:0]                                  cfg_pad_post,
`endif
    input  logic                                        mem_ext_rd,
    output logic                                        rd_enable,
    output logic [SRAM_totalWordAddr-1:0]               rd_addr,
    input  logic [SRAM_numBit*SRAM_blocks_per_row-1:0]  rd_data,
    output logic                                        out_valid,
    output logic [SRAM_numBit*SRAM_blocks_per_row-1:0]  out_data,
    input  logic                                        out_ready,
    output logic                                        busy,
    output logic                                        done
);

    localparam int unsigned DW = SRAM_numBit * SRAM_blocks_per_row;
    localparam int unsigned AW = SRAM_totalWordAddr;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = LEN_W + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_RUN,
        S_POST,
        S_DRAIN
    } state_t;

    state_t         state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [AW-1:0]  stride_q, stride_d;
    logic [AW-1:0]  next_addr_q, next_addr_d;
    logic [AW-1:0]  last_addr_q, last_addr_d;
    logic [LEN_W-1:0] issued_q, issued_d;
    logic [TW-1:0]  popped_q, popped_d;
    logic [TW-1:0]  total_q, total_d;
    logic           inflight_q, inflight_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [DW-1:0]  mem_q [FIFO_DEPTH];
`ifdef ACT_STREAMER_ZERO_PAD_EN
    logic [3:0]     pre_left_q, pre_left_d;
    logic [3:0]     post_left_q, post_left_d;
`endif

    logic [CW:0]    occ;
    logic           credit_ok;
    logic           issue;
    logic           zero_push;
    logic           push;
    logic           pop;
    logic           wr_en;
    logic [DW-1:0]  wr_data;
    logic [TW-1:0]  tot_cfg;
    state_t         first_state;
    state_t         after_run;

    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign rd_enable = issue;
    assign rd_addr   = issue ? next_addr_q : last_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // Credits count both buffered words and the read whose data returns next edge.
    always_comb begin
        occ       = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
        credit_ok = (occ < DEPTH_C);
        issue     = (state_q == S_RUN) && !mem_ext_rd && credit_ok && (issued_q < len_q);
`ifdef ACT_STREAMER_ZERO_PAD_EN
        zero_push = ((state_q == S_PRE) || (state_q == S_POST)) && !inflight_q && credit_ok;
        tot_cfg   = TW'(cfg_len) + TW'(cfg_pad_pre) + TW'(cfg_pad_post);
        if (cfg_pad_pre != '0) begin
            first_state = S_PRE;
        end else if (cfg_len != '0) begin
            first_state = S_RUN;
        end else begin
            first_state = S_POST;
        end
        after_run = (post_left_q != '0) ? S_POST : S_DRAIN;
`else
        zero_push   = 1'b0;
        tot_cfg     = TW'(cfg_len);
        first_state = S_RUN;
        after_run   = S_DRAIN;
`endif
        push    = inflight_q || zero_push;
        pop     = out_valid && out_ready;
        wr_en   = push && !clear;
        wr_data = inflight_q ? rd_data : '0;
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        stride_d    = stride_q;
        next_addr_d = next_addr_q;
        last_addr_d = last_addr_q;
        issued_d    = issued_q;
        popped_d    = popped_q;
        total_d     = total_q;
        inflight_d  = issue;
        busy_d      = busy_q;
        done_d      = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
`ifdef ACT_STREAMER_ZERO_PAD_EN
        pre_left_d  = pre_left_q;
        post_left_d = post_left_q;
`endif

        if (issue) begin
            next_addr_d = next_addr_q + stride_q;
            last_addr_d = next_addr_q;
            issued_d    = issued_q + LEN_W'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            popped_d = popped_q + TW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d       = cfg_len;
                    stride_d    = cfg_stride;
                    next_addr_d = cfg_base;
                    issued_d    = '0;
                    popped_d    = '0;
                    total_d     = tot_cfg;
`ifdef ACT_STREAMER_ZERO_PAD_EN
                    pre_left_d  = cfg_pad_pre;
                    post_left_d = cfg_pad_post;
`endif
                    if (tot_cfg == '0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = first_state;
                    end
                end
            end
`ifdef ACT_STREAMER_ZERO_PAD_EN
            S_PRE: begin
                if (zero_push) begin
                    pre_left_d = pre_left_q - 4'd1;
                    if (pre_left_q == 4'd1) begin
                        if (len_q != '0) begin
                            state_d = S_RUN;
                        end else begin
                            state_d = (post_left_q != '0) ? S_POST : S_DRAIN;
                        end
                    end
                end
            end
            S_POST: begin
                if (zero_push) begin
                    post_left_d = post_left_q - 4'd1;
                    if (post_left_q == 4'd1) begin
                        state_d = S_DRAIN;
                    end
                end
            end
`endif
            S_RUN: begin
                if (issue && (issued_q + LEN_W'(1) == len_q)) begin
                    state_d = after_run;
                end
            end
            S_DRAIN: begin
                if (pop && (popped_q + TW'(1) == total_q)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort drops buffered words and the data of any read issued this cycle.
        if (clear) begin
            state_d     = S_IDLE;
            len_d       = '0;
            stride_d    = '0;
            next_addr_d = '0;
            last_addr_d = '0;
            issued_d    = '0;
            popped_d    = '0;
            total_d     = '0;
            inflight_d  = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
`ifdef ACT_STREAMER_ZERO_PAD_EN
            pre_left_d  = '0;
            post_left_d = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            stride_q    <= '0;
            next_addr_q <= '0;
            last_addr_q <= '0;
            issued_q    <= '0;
            popped_q    <= '0;
            total_q     <= '0;
            inflight_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
`ifdef ACT_STREAMER_ZERO_PAD_EN
            pre_left_q  <= '0;
            post_left_q <= '0;
`endif
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            stride_q    <= stride_d;
            next_addr_q <= next_addr_d;
            last_addr_q <= last_addr_d;
            issued_q    <= issued_d;
            popped_q    <= popped_d;
            total_q     <= total_d;
            inflight_q  <= inflight_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
`ifdef ACT_STREAMER_ZERO_PAD_EN
            pre_left_q  <= pre_left_d;
            post_left_q <= post_left_d;
`endif
            if (wr_en) begin
                mem_q[wr_ptr_q] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_act_mem_rd_streamer.sv
// Bench for act_mem_rd_streamer: directed plan steps plus randomized transactions
// against a word-list reference model (memory image, address list, delivery order).
module tb_act_mem_rd_streamer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic [9:0]  cfg_base = '0;
    logic [9:0]  cfg_stride = '0;
    logic [11:0] cfg_len = '0;
`ifdef ACT_STREAMER_ZERO_PAD_EN
    logic [3:0]  cfg_pad_pre = '0;
    logic [3:0]  cfg_pad_post = '0;
`endif
    logic        mem_ext_rd = 1'b0;
    logic        rd_enable;
    logic [9:0]  rd_addr;
    logic [31:0] rd_data = '0;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        done;

    act_mem_rd_streamer #(
        .SRAM_numBit(8),
        .SRAM_blocks_per_row(4),
        .SRAM_totalWordAddr(10),
        .FIFO_DEPTH(DEPTH),
        .LEN_W(12)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .clear(clear),
        .cfg_base(cfg_base),
        .cfg_stride(cfg_stride),
        .cfg_len(cfg_len),
`ifdef ACT_STREAMER_ZERO_PAD_EN
        .cfg_pad_pre(cfg_pad_pre),
        .cfg_pad_post(cfg_pad_post),
`endif
        .mem_ext_rd(mem_ext_rd),
        .rd_enable(rd_enable),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    logic [31:0] mem_img [1024];

    // One-cycle-latency memory; garbage returned when no read was issued.
    always @(posedge clk) begin
        rd_data <= rd_enable ? mem_img[rd_addr] : $urandom;
    end

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int exp_addr[$];
    int exp_word[$];
    int issue_idx, pop_idx, pre_n;
    int exp_done_cyc = -1;
    bit busy_m = 1'b0;
    bit done_seen;
    int start_cyc, first_issue_cyc, last_issue_cyc, first_valid_cyc, done_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        bit last_pop;
        @(negedge clk);
        chk("done", done, cyc == exp_done_cyc);
        chk("busy", busy, busy_m);
        if (done) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
        if (rd_enable) begin
            chk("ext_rd_block", mem_ext_rd, 1'b0);
            if (issue_idx < exp_addr.size()) chk("rd_addr", rd_addr, exp_addr[issue_idx]);
            else chk("issue_count", issue_idx + 1, exp_addr.size());
            chk("credit", (pre_n + issue_idx - pop_idx) < DEPTH, 1'b1);
            if (first_issue_cyc < 0) first_issue_cyc = cyc;
            last_issue_cyc = cyc;
            issue_idx++;
        end
        if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        last_pop = 1'b0;
        if (out_valid && out_ready) begin
            if (pop_idx < exp_word.size()) chk("out_data", out_data, exp_word[pop_idx]);
            else chk("pop_count", pop_idx + 1, exp_word.size());
            pop_idx++;
            last_pop = (pop_idx == exp_word.size());
        end
        if (clear) begin
            busy_m = 1'b0;
            exp_done_cyc = -1;
        end else if (start && !busy_m) begin
            if (exp_word.size() == 0) exp_done_cyc = cyc + 1;
            else busy_m = 1'b1;
        end else if (last_pop && busy_m) begin
            busy_m = 1'b0;
            exp_done_cyc = cyc + 1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic begin_txn(input int base, input int stride, input int len,
                             input int pre, input int post);
        exp_addr.delete();
        exp_word.delete();
        for (int k = 0; k < pre; k++) exp_word.push_back(0);
        for (int k = 0; k < len; k++) begin
            int a;
            a = (base + k * stride) % 1024;
            exp_addr.push_back(a);
            exp_word.push_back(mem_img[a]);
        end
        for (int k = 0; k < post; k++) exp_word.push_back(0);
        pre_n = pre;
        issue_idx = 0;
        pop_idx = 0;
        done_seen = 1'b0;
        first_issue_cyc = -1;
        last_issue_cyc = -1;
        first_valid_cyc = -1;
        done_cyc = -1;
        start_cyc = cyc;
        cfg_base = 10'(base);
        cfg_stride = 10'(stride);
        cfg_len = 12'(len);
`ifdef ACT_STREAMER_ZERO_PAD_EN
        cfg_pad_pre = 4'(pre);
        cfg_pad_post = 4'(post);
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_done(input int budget, input int rdy_pct, input int ext_pct);
        int n;
        n = 0;
        while (!done_seen && n < budget) begin
            out_ready  = ($urandom_range(0, 99) < rdy_pct);
            mem_ext_rd = ($urandom_range(0, 99) < ext_pct);
            start      = busy_m && ($urandom_range(0, 99) < 5);
            if (start) begin
                cfg_base = 10'($urandom);
                cfg_len  = 12'($urandom);
            end
            tick();
            n++;
        end
        start = 1'b0;
        mem_ext_rd = 1'b0;
        chk("done_reached", done_seen, 1'b1);
        chk("words_delivered", pop_idx, exp_word.size());
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem_img[i] = $urandom;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_rd_enable", rd_enable, 1'b0);
        chk("rst_rd_addr", rd_addr, 10'h0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Basic timing: reads cycles 1-3, valid from cycle 3, done in cycle 6.
        out_ready = 1'b1;
        begin_txn(32'h10, 4, 3, 0, 0);
        run_until_done(50, 100, 0);
        chk("t1_first_issue", first_issue_cyc - start_cyc, 1);
        chk("t1_last_issue", last_issue_cyc - start_cyc, 3);
        chk("t1_first_valid", first_valid_cyc - start_cyc, 3);
        chk("t1_done", done_cyc - start_cyc, 6);

        // Sustained throughput of one word per cycle.
        out_ready = 1'b1;
        begin_txn(32'h40, 4, 16, 0, 0);
        run_until_done(80, 100, 0);
        chk("thru_done", done_cyc - start_cyc, 16 + 3);

        // Backpressure: only DEPTH reads outstanding, nothing lost afterwards.
        out_ready = 1'b0;
        begin_txn(32'h100, 4, 8, 0, 0);
        repeat (10) tick();
        chk("bp_issue_count", issue_idx, DEPTH);
        chk("bp_out_valid", out_valid, 1'b1);
        run_until_done(80, 100, 0);

        // External reads stall issue in cycles 2-4.
        out_ready = 1'b1;
        begin_txn(32'h200, 4, 4, 0, 0);
        tick();
        mem_ext_rd = 1'b1;
        repeat (3) tick();
        mem_ext_rd = 1'b0;
        chk("ext_issue_count", issue_idx, 1);
        run_until_done(50, 100, 0);

        // Address wrap.
        begin_txn(32'h3FC, 4, 2, 0, 0);
        run_until_done(50, 100, 0);

        // Zero-length start.
        begin_txn(32'h55, 4, 0, 0, 0);
        run_until_done(10, 100, 0);

        // Clear with words buffered and a read in flight.
        out_ready = 1'b0;
        begin_txn(32'h300, 4, 8, 0, 0);
        repeat (3) tick();
        chk("clr_pre_valid", out_valid, 1'b1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_out_valid", out_valid, 1'b0);
        chk("clr_busy", busy, 1'b0);
        chk("clr_done", done, 1'b0);
        chk("clr_rd_enable", rd_enable, 1'b0);
        chk("clr_rd_addr", rd_addr, 10'h0);
        chk("clr_out_data", out_data, 32'h0);
        out_ready = 1'b1;
        begin_txn(32'h20, 8, 3, 0, 0);
        run_until_done(50, 100, 0);
        chk("clr_restart_done", done_cyc - start_cyc, 6);

`ifdef ACT_STREAMER_ZERO_PAD_EN
        begin_txn(32'h80, 4, 2, 1, 1);
        run_until_done(50, 100, 0);
`endif

        // Randomized transactions with random ready and external-read stalls.
        for (int t = 0; t < 25; t++) begin
            int pre, post;
            pre = 0;
            post = 0;
`ifdef ACT_STREAMER_ZERO_PAD_EN
            pre = $urandom_range(0, 3);
            post = $urandom_range(0, 3);
`endif
            out_ready = ($urandom_range(0, 1) == 1);
            begin_txn($urandom_range(0, 1023),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : 4,
                      $urandom_range(0, 20), pre, post);
            run_until_done(400, 70, 25);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
